// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state encoding, code width and counter sizing for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [2:0] {IDLE, ON, OFF, GAP, DONE} state_t;

    localparam int COUNT_W = 4;

    function automatic int cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: enabled modulo-DIV counter with synchronous clear and a single-cycle tick on its last count.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int W = cnt_w(DIV);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: fixed-priority arbiter sharing one LED between blink-code requesters, heartbeat when idle.
module led_blink_sequencer
    import led_seq_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int TICK_DIV  = 500,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 8,
    parameter int HB_TICKS  = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [COUNT_W*NREQ-1:0]   count,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           done,
    output logic                      busy,
    output logic                      led
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_W   = cnt_w((ON_OFF > GAP_TICKS) ? ON_OFF : GAP_TICKS);

    if (NREQ < 1 || NREQ > 8 || TICK_DIV < 1 || ON_TICKS < 1 || OFF_TICKS < 1 ||
        GAP_TICKS < 1 || HB_TICKS < 1) begin : g_bad_params
        $error("led_blink_sequencer: parameter out of range");
    end

    state_t             state;
    logic [IDX_W-1:0]   win;
    logic               any;
    logic [COUNT_W-1:0] code;
    logic [COUNT_W-1:0] rem;
    logic [PH_W-1:0]    ph;
    logic [PH_W-1:0]    lim;
    logic               tick;
    logic               hb_tick;
    logic               hb;
    logic               hold;
    logic               start;
    logic               last;
    logic               clear;

    always_comb begin
        win = '0;
        any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i]) begin
                win = IDX_W'(i);
                any = 1'b1;
            end
    end

    assign code  = count[win*COUNT_W +: COUNT_W];
    assign busy  = state != IDLE;
    assign start = state == IDLE && any && !hold;
    assign lim   = state == ON  ? PH_W'(ON_TICKS - 1) :
                   state == OFF ? PH_W'(OFF_TICKS - 1) : PH_W'(GAP_TICKS - 1);
    assign last  = tick && ph == lim && (state == ON || state == OFF || state == GAP);
    // Restarting the prescaler on every state change makes each phase an exact multiple of TICK_DIV.
    assign clear = start || last || state == DONE;

    led_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (1'b1),
        .tick  (tick)
    );

    led_tick_gen #(.DIV(HB_TICKS)) u_hb (
        .clk   (clk),
        .reset (reset),
        .clear (clear || state != IDLE),
        .en    (tick),
        .tick  (hb_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            led   <= 1'b1;
            hb    <= 1'b1;
            grant <= '0;
            done  <= '0;
            ph    <= '0;
            rem   <= '0;
            hold  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold <= 1'b0;
                    ph   <= '0;
                    if (start) begin
                        rem   <= code;
                        grant <= NREQ'(1) << win;
                        state <= (code != '0) ? ON : DONE;
                        done  <= (code != '0) ? '0 : NREQ'(1) << win;
                        led   <= code != '0;
                    end else if (hb_tick) begin
                        hb  <= ~hb;
                        led <= ~hb;
                    end
                end
                ON, OFF, GAP: begin
                    if (tick)
                        ph <= last ? '0 : ph + 1'b1;
                    if (last) begin
                        if (state == ON) begin
                            rem   <= rem - 1'b1;
                            state <= (rem == COUNT_W'(1)) ? GAP : OFF;
                            led   <= 1'b0;
                        end else if (state == OFF) begin
                            state <= ON;
                            led   <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= grant;
                        end
                    end
                end
                DONE: begin
                    // Holdoff gives the served requester one cycle to drop req before re-arbitration.
                    state <= IDLE;
                    done  <= '0;
                    grant <= '0;
                    led   <= 1'b1;
                    hb    <= 1'b1;
                    hold  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    assert property (@(posedge clk) disable iff (reset) (done != '0) |-> (state == DONE));

endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb_led_blink_sequencer: directed vector table plus hand-written corner sequences for led_blink_sequencer.
module tb_led_blink_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_a = '0, req_b = '0;
    logic [15:0] count_a = '0, count_b = '0;
    logic [3:0]  grant_a, done_a, grant_b, done_b;
    logic        busy_a, led_a, busy_b, led_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_blink_sequencer #(
        .NREQ(4), .TICK_DIV(1), .ON_TICKS(2), .OFF_TICKS(2), .GAP_TICKS(3), .HB_TICKS(4)
    ) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .count(count_a),
        .grant(grant_a), .done(done_a), .busy(busy_a), .led(led_a)
    );

    led_blink_sequencer #(
        .NREQ(4), .TICK_DIV(500), .ON_TICKS(2), .OFF_TICKS(2), .GAP_TICKS(3), .HB_TICKS(4)
    ) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .count(count_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .led(led_b)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] cnt;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic        busy;
        logic        led;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_a = '0;
        req_b = '0;
        repeat (n) step();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_done(input bit b, inout int pulses, output logic [3:0] d);
        logic pl;
        d = '0;
        for (int i = 0; i < 20000; i++) begin
            pl = b ? led_b : led_a;
            step();
            if ((b ? led_b : led_a) && !pl)
                pulses++;
            d = b ? done_b : done_a;
            if (d != '0)
                break;
        end
    endtask

    initial begin
        logic [3:0] d;
        logic [3:0] seen;
        int pulses;
        int n;

        // reset, then heartbeat: led high for 4 cycles, low for 4
        tbl.push_back('{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1});
        // req[2] with a 3-pulse code
        tbl.push_back('{1'b0, 4'b0100, 16'h0300, 4'b0100, 4'b0000, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0100, 4'b0100, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1});

        #1;
        foreach (tbl[i]) begin
            reset   = tbl[i].rst;
            req_a   = tbl[i].req;
            count_a = tbl[i].cnt;
            step();
            chk($sformatf("vec%0d", i), {grant_a, done_a, busy_a, led_a},
                {tbl[i].grant, tbl[i].done, tbl[i].busy, tbl[i].led});
        end

        // simultaneous req[1] and req[3]; holdoff before serving req[3]
        idle(2);
        req_a   = 4'b1010;
        count_a = 16'h1010;
        step();
        chk("prio_grant", grant_a, 4'b0010);
        pulses = 0;
        wait_done(1'b0, pulses, d);
        chk("prio_done1", d, 4'b0010);
        step();
        chk("holdoff_idle", {grant_a, led_a, busy_a}, {4'b0000, 1'b1, 1'b0});
        req_a = 4'b1000;
        step();
        chk("holdoff_nogrant", grant_a, 4'b0000);
        step();
        chk("second_grant", grant_a, 4'b1000);
        req_a = '0;
        wait_done(1'b0, pulses, d);
        chk("prio_done3", d, 4'b1000);

        // zero-length code goes straight to DONE
        idle(2);
        req_a   = 4'b0001;
        count_a = 16'h0000;
        step();
        chk("zero_done", {done_a, grant_a, busy_a, led_a}, {4'b0001, 4'b0001, 1'b1, 1'b0});
        req_a = '0;
        step();
        chk("zero_after", {done_a, grant_a, busy_a, led_a}, {4'b0000, 4'b0000, 1'b0, 1'b1});

        // reset during ON of a 5-pulse code
        idle(2);
        req_a   = 4'b0001;
        count_a = 16'h0005;
        step();
        chk("rst_on", {busy_a, led_a}, 2'b11);
        step();
        reset = 1'b1;
        step();
        chk("rst_mid", {grant_a, done_a, busy_a, led_a}, {4'b0000, 4'b0000, 1'b0, 1'b1});
        reset = 1'b0;
        req_a = '0;
        seen  = '0;
        repeat (40) begin
            step();
            seen |= done_a | grant_a;
        end
        chk("rst_no_done", seen, 4'b0000);

        // req dropped and count changed after latching a 2-pulse code
        idle(2);
        req_a   = 4'b0001;
        count_a = 16'h0002;
        step();
        chk("latch_grant", {grant_a, led_a}, {4'b0001, 1'b1});
        pulses  = 1;
        req_a   = '0;
        count_a = 16'h0009;
        wait_done(1'b0, pulses, d);
        chk("latch_done", d, 4'b0001);
        chk("latch_pulses", pulses, 2);

        // same with TICK_DIV=500: ON phase is 1000 cycles
        req_b   = 4'b0001;
        count_b = 16'h0002;
        step();
        chk("slow_grant", {grant_b, led_b}, {4'b0001, 1'b1});
        req_b   = '0;
        count_b = 16'h0009;
        n = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!led_b)
                break;
            n++;
        end
        chk("slow_on_len", n, 1000);
        pulses = 1;
        wait_done(1'b1, pulses, d);
        chk("slow_done", d, 4'b0001);
        chk("slow_pulses", pulses, 2);
        step();
        chk("slow_idle", {grant_b, busy_b, led_b}, {4'b0000, 1'b0, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
